fact_bus_if: RTL and testbench
==============================

FACT_BUS_IF -- requirements
Module: fact_bus_if

Interface
REQ-001 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have port we, input, 1, bus write enable for the current cycle.
REQ-004 The block SHALL have port a, input, 2, register select: 0=N, 1=GO, 2=STATUS, 3=RESULT.
REQ-005 The block SHALL have port wd, input, 32, bus write data.
REQ-006 The block SHALL have port rd, output, 32, bus read data, combinational from a.
REQ-007 The block SHALL have port n_out, output, 4, operand to the factorial core.
REQ-008 The block SHALL have port go_out, output, 1, one-cycle start pulse to the factorial core.
REQ-009 The block SHALL have port done_in, input, 1, core completion indication.
REQ-010 The block SHALL have port error_in, input, 1, core operand-out-of-range indication.
REQ-011 The block SHALL have port result_in, input, 32, core result bus.

Function
REQ-012 FSM states SHALL be IDLE, START, RUN, CAPT; reset state IDLE.
REQ-013 Write to a=0 in IDLE SHALL load n_reg <= wd[3:0]; writes to a=0 in any other state SHALL be ignored.
REQ-014 Write to a=1 with wd[0]=1 in IDLE SHALL clear done_st and err_st and move to START next cycle; wd[0]=0 or any non-IDLE state SHALL be ignored.
REQ-015 Writes to a=2 and a=3 SHALL have no effect.
REQ-016 go_out SHALL be 1 only in START, exactly one cycle per accepted start.
REQ-017 In START: error_in=1 SHALL set err_st=1, done_st=1, result_reg=0, next IDLE; else next RUN.
REQ-018 In RUN: error_in=1 SHALL act as REQ-017; else done_in=1 SHALL move to CAPT; else stay RUN.
REQ-019 In CAPT: result_reg <= result_in, done_st <= 1, next IDLE (result sampled the cycle after done_in first seen in RUN).
REQ-020 done_in and error_in SHALL be ignored in IDLE and CAPT.
REQ-021 busy SHALL be 1 in START, RUN, CAPT; 0 in IDLE.
REQ-022 rd SHALL be: a=0 {28'b0,n_reg}; a=1 {31'b0,busy}; a=2 {29'b0,busy,err_st,done_st}; a=3 result_reg.
REQ-023 n_out SHALL equal n_reg continuously; n_reg SHALL be stable from START through CAPT.
REQ-024 done_st and err_st SHALL be sticky until the next accepted start or reset.
REQ-025 Read has no side effects; simultaneous read and write of the same register SHALL return pre-write value.

Reset
REQ-026 On rst=1 at a clock edge: state IDLE, n_reg=0, result_reg=0, done_st=0, err_st=0, go_out=0, regardless of current state.
REQ-027 Reset during RUN SHALL abandon the operation; later done_in/error_in SHALL not change status until a new start.

Verification
REQ-028 Write a=0 wd=5, write a=1 wd=1, core completes -> go_out one pulse; status reads 0x1 after CAPT; a=3 reads 0x78.
REQ-029 n=0 start -> result 0x1, status 0x1; n=12 -> result 0x1C8CFC00.
REQ-030 n=13 start, core asserts error_in in START -> status 0x3, result 0x0, no RUN cycle.
REQ-031 Write a=0 wd=0xFFFFFFF7 -> a=0 reads 0x7; write a=0 wd=3 while busy -> a=0 still 0x7.
REQ-032 Second GO write during RUN -> no extra go_out pulse, status busy bit stays 1 until CAPT.
REQ-033 rst asserted in RUN -> next cycle status 0x0, result 0x0; done_in pulse afterward leaves status 0x0.

Source files
------------

// File: rtl/fact_bus_if_if.sv
// ============================================================================
//  Module   : fact_bus_if_if
//  Purpose  : Register bus bundle between a bus master and fact_bus_if.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fact_bus_if_if;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, output a, output wd, input rd);
    modport slave  (input we, input a, input wd, output rd);
endinterface

`default_nettype wire

// File: rtl/fact_bus_if.sv
// ============================================================================
//  Module   : fact_bus_if
//  Purpose  : Bus register front-end that launches a factorial core and
//             captures its result and status.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fact_bus_if (
    input  wire logic        clk,
    input  wire logic        rst,
    fact_bus_if_if.slave     bus,
    output      logic [3:0]  n_out,
    output      logic        go_out,
    input  wire logic        done_in,
    input  wire logic        error_in,
    input  wire logic [31:0] result_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    localparam logic [1:0] c_A_N      = 2'd0;
    localparam logic [1:0] c_A_GO     = 2'd1;
    localparam logic [1:0] c_A_STATUS = 2'd2;

    state_t      state_q;
    logic [3:0]  n_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        err_q;
    logic        go_q;
    logic        w_busy;

    assign w_busy = (state_q != S_IDLE);
    assign n_out  = n_q;
    assign go_out = go_q;

    // go_q is raised on the same edge that enters START, so it is high
    // exactly while the FSM sits in START.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= 4'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.we && bus.a == c_A_N) begin
                        n_q <= bus.wd[3:0];
                    end
                    if (bus.we && bus.a == c_A_GO && bus.wd[0]) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        go_q    <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START, S_RUN: begin
                    if (error_in) begin
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        result_q <= 32'd0;
                        state_q  <= S_IDLE;
                    end else if (state_q == S_START) begin
                        state_q <= S_RUN;
                    end else if (done_in) begin
                        state_q <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    result_q <= result_in;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Reads come straight from registers, so a read coinciding with a write
    // returns the value held before that write.
    always_comb begin
        bus.rd = result_q;
        case (bus.a)
            c_A_N:      bus.rd = {28'd0, n_q};
            c_A_GO:     bus.rd = {31'd0, w_busy};
            c_A_STATUS: bus.rd = {29'd0, w_busy, err_q, done_q};
            default:    bus.rd = result_q;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fact_bus_if.sv
// ============================================================================
//  Module   : tb_fact_bus_if
//  Purpose  : Self-checking bench for fact_bus_if with a behavioural core.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fact_bus_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  n_out;
    logic        go_out;
    logic        done_in;
    logic        error_in;
    logic [31:0] result_in;

    logic        model_done = 1'b0;
    logic        man_done   = 1'b0;
    logic        man_err    = 1'b0;
    logic        active     = 1'b0;
    int          cnt        = 0;
    int          go_cnt     = 0;
    int          checks     = 0;
    int          errors     = 0;

    typedef struct packed {
        logic [31:0] status;
        logic [31:0] result;
    } exp_t;
    exp_t sb_q[$];

    fact_bus_if_if bif();

    fact_bus_if dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .n_out     (n_out),
        .go_out    (go_out),
        .done_in   (done_in),
        .error_in  (error_in),
        .result_in (result_in)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * i;
        return p;
    endfunction

    // Behavioural core: out-of-range operands error during START, others
    // complete after a fixed latency with the result held afterwards.
    assign error_in = (go_out && n_out > 4'd12) | man_err;
    assign done_in  = model_done | man_done;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (go_out) go_cnt <= go_cnt + 1;
        if (go_out && n_out <= 4'd12) begin
            active    <= 1'b1;
            cnt       <= 8;
            result_in <= fact(n_out);
        end else if (active) begin
            if (cnt == 0) begin
                model_done <= 1'b1;
                active     <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bif.we = 1'b1; bif.a = addr; bif.wd = data;
        @(negedge clk);
        bif.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        bif.a = addr;
        #1 data = bif.rd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue_start(input logic [3:0] n);
        exp_t e;
        bus_write(2'd0, {28'd0, n});
        bus_write(2'd1, 32'd1);
        e.status = (n > 4'd12) ? 32'h3 : 32'h1;
        e.result = (n > 4'd12) ? 32'h0 : fact(n);
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] v;
        int i;
        for (i = 0; i < 60; i++) begin
            bus_read(2'd1, v);
            if (v[0] == 1'b0) break;
        end
        if (i == 60) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting idle, busy=1 expected busy=0", name);
        end
    endtask

    task automatic finish_op(input string name);
        exp_t e;
        logic [31:0] v;
        wait_idle(name);
        e = sb_q.pop_front();
        bus_read(2'd2, v);
        check({name, "_status"}, v, e.status);
        bus_read(2'd3, v);
        check({name, "_result"}, v, e.result);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            bus_read(i[1:0], v);
            check($sformatf("reset_reg%0d", i), v, 32'd0);
        end
        check("reset_go", {31'd0, go_out}, 32'd0);
    endtask

    task automatic test_basic();
        int g0;
        g0 = go_cnt;
        issue_start(4'd5);
        finish_op("basic_n5");
        check("basic_go_pulses", go_cnt - g0, 32'd1);
    endtask

    task automatic test_boundary();
        issue_start(4'd0);
        finish_op("n0");
        issue_start(4'd12);
        finish_op("n12");
    endtask

    task automatic test_error_start();
        logic [31:0] v;
        bus_write(2'd0, 32'd13);
        bus_write(2'd1, 32'd1);
        bus_read(2'd2, v);
        check("err_start_no_run", v, 32'h3);
        bus_read(2'd3, v);
        check("err_start_result", v, 32'h0);
    endtask

    task automatic test_error_run();
        exp_t e;
        issue_start(4'd3);
        void'(sb_q.pop_front());
        e.status = 32'h3; e.result = 32'h0;
        sb_q.push_back(e);
        repeat (2) @(negedge clk);
        man_err = 1'b1;
        @(negedge clk);
        man_err = 1'b0;
        finish_op("err_run");
        repeat (12) @(negedge clk);
    endtask

    task automatic test_mask_busy();
        logic [31:0] v;
        int g0;
        bus_write(2'd0, 32'hFFFF_FFF7);
        bus_read(2'd0, v);
        check("n_mask", v, 32'h7);
        g0 = go_cnt;
        issue_start(4'd7);
        bus_write(2'd0, 32'd3);
        bus_read(2'd0, v);
        check("n_busy_ignored", v, 32'h7);
        check("n_out_stable", {28'd0, n_out}, 32'h7);
        bus_write(2'd1, 32'd1);
        bus_read(2'd2, v);
        check("second_go_busy", v, 32'h4);
        finish_op("busy_n7");
        check("second_go_pulses", go_cnt - g0, 32'd1);
    endtask

    task automatic test_rw_same();
        logic [31:0] v;
        @(negedge clk);
        bif.we = 1'b1; bif.a = 2'd0; bif.wd = 32'd9;
        #1 v = bif.rd;
        check("rw_same_prewrite", v, 32'h7);
        @(negedge clk);
        bif.we = 1'b0;
        bus_read(2'd0, v);
        check("rw_same_postwrite", v, 32'h9);
        bus_write(2'd3, 32'hDEAD_BEEF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd3, v);
        check("ro_result", v, fact(4'd7));
        bus_read(2'd2, v);
        check("ro_status", v, 32'h1);
    endtask

    task automatic test_reset_run();
        logic [31:0] v;
        issue_start(4'd4);
        void'(sb_q.pop_front());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'd2, v);
        check("rst_run_status", v, 32'h0);
        bus_read(2'd3, v);
        check("rst_run_result", v, 32'h0);
        repeat (12) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        bus_read(2'd2, v);
        check("rst_run_late_done", v, 32'h0);
    endtask

    initial begin
        bif.we = 1'b0; bif.a = 2'd0; bif.wd = 32'd0;
        result_in = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_error_start();
        test_error_run();
        test_mask_busy();
        test_rw_same();
        test_reset_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
